nonce_collector: RTL and testbench
==================================

# nonce_collector

Parametrised result-collection stage for the mining cluster hub. It accepts nonce reports from `SLAVES` receive channels and buffers them in one FIFO per channel, so bursts are not lost. It grants channels round-robin and feeds one nonce at a time to the hub's `serial_transmit` uplink through a send/busy handshake. It replaces the fixed two-slave, priority-ordered, single-flag collection logic in the hub top level.

## Interface

Parameters:
- `SLAVES`, 2: number of receive channels (local miners plus external ports), ≥1.
- `NONCE_W`, 32: nonce word width.
- `DEPTH_LOG2`, 1: per-channel FIFO depth is 2^`DEPTH_LOG2` entries, ≥1.

Ports (one clock; reset is asynchronous and active-high):
- `hash_clk`  in  1  sole clock; all state is updated on the rising edge.
- `reset`  in  1  async active-high reset.
- `slave_nonces`  in  `SLAVES*NONCE_W`  channel i nonce at `[i*NONCE_W +: NONCE_W]`.
- `new_nonces`  in  `SLAVES`  1-cycle strobe per channel; the nonce is valid in the same cycle.
- `serial_busy`  in  1  uplink transmitter busy.
- `serial_send`  out  1  1-cycle send strobe to the uplink.
- `golden_nonce`  out  `NONCE_W`  word presented to the uplink; held stable until the next grant.
- `overflow`  out  `SLAVES`  sticky per-channel flag for a dropped nonce; cleared only by `reset`.
- `pending`  out  1  high while any FIFO is non-empty.

## Operation

- Reset value of all outputs is 0. FIFOs are empty, the round-robin pointer `rr_ptr` is 0, and the FSM is in IDLE.
- Per-channel FIFO write:
  - When `new_nonces[i]` is high, the nonce is written if count < DEPTH, or if the same FIFO is popped in that cycle.
  - Otherwise the nonce is dropped and `overflow[i]` is set.
  - Read and write pointers are `DEPTH_LOG2` bits wide and wrap naturally. The count is `DEPTH_LOG2+1` bits wide.
- Arbiter: the grant goes to the first non-empty channel at or after `rr_ptr`, searching upward modulo `SLAVES`. On a grant, `rr_ptr` is set to grant+1, wrapping to 0 at `SLAVES`.
- FSM:
  - IDLE: when `!serial_busy` and any FIFO is non-empty, pop the granted head into `golden_nonce` and go to SEND.
  - SEND: `serial_send` is 1 for exactly this cycle. Go to ACK.
  - ACK: wait for `serial_busy`=1, then go to DRAIN.
  - DRAIN: wait for `serial_busy`=0, then go to IDLE.
- Only one nonce is in flight at a time. No strobe is issued while `serial_busy` is high or before the previous word has been acknowledged.
- Simultaneous strobes on all channels in one cycle are all written, subject to per-channel space.

## Timing

- The FIFO write takes effect at the edge after the strobe (cycle t+1).
- With the FSM in IDLE and the uplink idle, a strobe at cycle t gives:
  - `golden_nonce` loaded at the edge ending cycle t+1;
  - `serial_send` high during cycle t+2.
- `pending` is registered from the FIFO counts and lags the counts by one cycle.
- Back-to-back throughput is one nonce per uplink frame plus 3 cycles of FSM overhead.
- Asserting `reset` mid-frame immediately returns the FSM to IDLE, empties the FIFOs, and drops `serial_send` asynchronously.

## Configuration

- `NONCE_DEDUP_EN`:
  - Defined: a `NONCE_W`-bit `last_sent` register and a valid bit are kept; both are reset to 0 and invalid. In IDLE, if the granted head equals `last_sent` and the valid bit is set, the head is popped and discarded. `rr_ptr` still advances, no strobe is issued, and the FSM stays in IDLE. Discarding does not require `serial_busy`=0.
  - Undefined: every accepted nonce is transmitted, including repeats.

## Test plan

- Single report: reset, then `new_nonces`=01 with ch0=0x12345678 at t=5 → `serial_send` pulses at t=7 with `golden_nonce`=0x12345678; `overflow`=0.
- Round-robin: both channels strobe in the same cycle (ch0=0xA, ch1=0xB), then again (0xC, 0xD), with the uplink model holding busy for 10 cycles per send → send order is 0xA, 0xB, 0xC, 0xD.
- Overflow: `DEPTH_LOG2`=1, busy held high, 3 strobes on ch1 → 2 entries buffered, `overflow`=10, and after busy drops exactly 2 sends occur.
- Full plus pop: ch0 FIFO full and being popped in IDLE while a new strobe arrives in the same cycle → the nonce is accepted, `overflow[0]` stays 0, and count stays 2.
- Reset mid-operation: `reset` asserted during ACK with 1 entry pending → `serial_send`=0, `pending`=0, and no further sends after release.
- With `NONCE_DEDUP_EN` defined: ch0 sends 0x55 twice → exactly one `serial_send`. Without the macro → two sends.

Source files
------------

// File: rtl/nonce_collector.sv
// nonce_collector: per-channel nonce FIFOs, round-robin grant, send/busy handshake to the uplink
// Ports: hash_clk/reset (async, active-high); slave_nonces/new_nonces carry one
// strobed nonce per channel; serial_busy/serial_send form the uplink handshake and
// golden_nonce is the word presented to it; overflow is a sticky per-channel drop
// flag; pending is a registered "any FIFO non-empty".
// Optional: define NONCE_DEDUP_EN to discard a granted head equal to the last word sent.
module nonce_collector #(
  parameter int SLAVES     = 2,
  parameter int NONCE_W    = 32,
  parameter int DEPTH_LOG2 = 1
) (
  input  logic                      hash_clk,
  input  logic                      reset,
  input  logic [SLAVES*NONCE_W-1:0] slave_nonces,
  input  logic [SLAVES-1:0]         new_nonces,
  input  logic                      serial_busy,
  output logic                      serial_send,
  output logic [NONCE_W-1:0]        golden_nonce,
  output logic [SLAVES-1:0]         overflow,
  output logic                      pending
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW = SLAVES > 1 ? $clog2(SLAVES) : 1;
  typedef enum logic [1:0] {IDLE, SEND, ACK, DRAIN} state_t;
  state_t state, state_nx;
  logic [NONCE_W-1:0] head [SLAVES];
  logic [SLAVES-1:0] nonempty, push, pop_ch;
  logic [PW-1:0] rr_ptr, grant;
  logic [PW:0] idx;
  logic [NONCE_W-1:0] head_g;
  logic any, pop, send_pop, discard;
  for (genvar i = 0; i < SLAVES; i++) begin : g_ch
    logic [NONCE_W-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0] cnt;
    logic ovf;
    assign pop_ch[i] = pop && grant == PW'(i);
    // a full FIFO still accepts when its head leaves in the same cycle
    assign push[i] = new_nonces[i] && (!cnt[DEPTH_LOG2] || pop_ch[i]);
    assign nonempty[i] = cnt != '0;
    assign head[i] = mem[rd_ptr];
    assign overflow[i] = ovf;
    always_ff @(posedge hash_clk)
      if (push[i]) mem[wr_ptr] <= slave_nonces[i*NONCE_W +: NONCE_W];
    always_ff @(posedge hash_clk or posedge reset)
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        ovf    <= 1'b0;
      end else begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(push[i]);
        rd_ptr <= rd_ptr + DEPTH_LOG2'(pop_ch[i]);
        cnt    <= cnt + (DEPTH_LOG2+1)'(push[i]) - (DEPTH_LOG2+1)'(pop_ch[i]);
        ovf    <= ovf | (new_nonces[i] & ~push[i]);
      end
  end
  assign any = |nonempty;
  // scan downward so the closest non-empty channel at or after rr_ptr wins last
  always_comb begin
    grant = rr_ptr;
    idx = '0;
    for (int k = SLAVES - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(k);
      idx = idx >= (PW+1)'(SLAVES) ? idx - (PW+1)'(SLAVES) : idx;
      grant = nonempty[PW'(idx)] ? PW'(idx) : grant;
    end
  end
  assign head_g = head[grant];
`ifdef NONCE_DEDUP_EN
  logic [NONCE_W-1:0] last_sent;
  logic last_valid;
  assign discard = last_valid && head_g == last_sent;
  always_ff @(posedge hash_clk or posedge reset)
    if (reset) begin
      last_sent  <= '0;
      last_valid <= 1'b0;
    end else if (send_pop) begin
      last_sent  <= head_g;
      last_valid <= 1'b1;
    end
`else
  assign discard = 1'b0;
`endif
  // a duplicate head is dropped without waiting for the uplink
  assign pop = state == IDLE && any && (discard || !serial_busy);
  assign send_pop = pop && !discard;
  always_ff @(posedge hash_clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (send_pop ? SEND : IDLE) :
               state == SEND ? ACK :
               state == ACK  ? (serial_busy ? DRAIN : ACK) :
                               (serial_busy ? DRAIN : IDLE);
  always_comb serial_send = state == SEND;
  always_ff @(posedge hash_clk or posedge reset)
    if (reset) begin
      rr_ptr       <= '0;
      golden_nonce <= '0;
      pending      <= 1'b0;
    end else begin
      pending <= any;
      if (pop) rr_ptr <= grant == PW'(SLAVES - 1) ? '0 : grant + 1'b1;
      if (send_pop) golden_nonce <= head_g;
    end
endmodule

// File: tb/tb_nonce_collector.sv
// tb_nonce_collector: table-driven and sequence checks of nonce_collector (SLAVES=2, DEPTH_LOG2=1)
module tb_nonce_collector;
  logic hash_clk = 1'b0;
  logic reset = 1'b1;
  logic [63:0] slave_nonces = '0;
  logic [1:0] new_nonces = '0;
  logic serial_busy = 1'b0;
  logic serial_send;
  logic [31:0] golden_nonce;
  logic [1:0] overflow;
  logic pending;
  int passed = 0;
  int total = 0;
  int busy_cnt = 0;
  logic model = 1'b0;
  logic [31:0] sent_q [$];
  typedef struct {
    logic [1:0] nn;
    logic [31:0] d0;
    logic [31:0] d1;
    logic busy;
    logic send;
    logic [31:0] golden;
    logic pend;
    logic [1:0] ovf;
  } vec_t;
  vec_t tbl [17];
  localparam logic [31:0] G = 32'h1234_5678;
  nonce_collector dut (
    .hash_clk(hash_clk), .reset(reset), .slave_nonces(slave_nonces),
    .new_nonces(new_nonces), .serial_busy(serial_busy), .serial_send(serial_send),
    .golden_nonce(golden_nonce), .overflow(overflow), .pending(pending)
  );
  always #5 hash_clk = ~hash_clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic tick(input logic [1:0] nn, input logic [31:0] d0, input logic [31:0] d1, input logic b);
    @(negedge hash_clk);
    new_nonces = nn;
    slave_nonces = {d1, d0};
    serial_busy = model ? busy_cnt > 0 : b;
    if (busy_cnt > 0) busy_cnt--;
    @(posedge hash_clk);
    #1;
    if (serial_send) begin
      sent_q.push_back(golden_nonce);
      if (model) busy_cnt = 10;
    end
  endtask
  task automatic do_reset();
    @(negedge hash_clk);
    reset = 1'b1;
    new_nonces = '0;
    slave_nonces = '0;
    serial_busy = 1'b0;
    model = 1'b0;
    busy_cnt = 0;
    repeat (2) @(posedge hash_clk);
    @(negedge hash_clk);
    reset = 1'b0;
    sent_q.delete();
  endtask
  initial begin
    logic [31:0] rr_exp [4];
    logic [31:0] fp_exp [3];
    int dedup_exp;
    rr_exp = '{32'hA, 32'hB, 32'hC, 32'hD};
    fp_exp = '{32'h1, 32'h2, 32'h3};
`ifdef NONCE_DEDUP_EN
    dedup_exp = 1;
`else
    dedup_exp = 2;
`endif
    tbl[0]  = '{2'b01, G, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00};
    tbl[1]  = '{2'b00, 32'h0, 32'h0, 1'b0, 1'b1, G, 1'b1, 2'b00};
    tbl[2]  = '{2'b00, 32'h0, 32'h0, 1'b0, 1'b0, G, 1'b0, 2'b00};
    tbl[3]  = '{2'b00, 32'h0, 32'h0, 1'b1, 1'b0, G, 1'b0, 2'b00};
    tbl[4]  = '{2'b10, 32'h0, 32'h111, 1'b1, 1'b0, G, 1'b0, 2'b00};
    tbl[5]  = '{2'b10, 32'h0, 32'h222, 1'b1, 1'b0, G, 1'b1, 2'b00};
    tbl[6]  = '{2'b10, 32'h0, 32'h333, 1'b1, 1'b0, G, 1'b1, 2'b10};
    tbl[7]  = '{2'b00, 32'h0, 32'h0, 1'b0, 1'b0, G, 1'b1, 2'b10};
    tbl[8]  = '{2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h111, 1'b1, 2'b10};
    tbl[9]  = '{2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h111, 1'b1, 2'b10};
    tbl[10] = '{2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h111, 1'b1, 2'b10};
    tbl[11] = '{2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h111, 1'b1, 2'b10};
    tbl[12] = '{2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h222, 1'b1, 2'b10};
    tbl[13] = '{2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h222, 1'b0, 2'b10};
    tbl[14] = '{2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h222, 1'b0, 2'b10};
    tbl[15] = '{2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h222, 1'b0, 2'b10};
    tbl[16] = '{2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h222, 1'b0, 2'b10};
    do_reset();
    #1;
    check("reset send", 32'(serial_send), 32'h0);
    check("reset golden", golden_nonce, 32'h0);
    check("reset overflow", 32'(overflow), 32'h0);
    check("reset pending", 32'(pending), 32'h0);
    for (int i = 0; i < 17; i++) begin
      tick(tbl[i].nn, tbl[i].d0, tbl[i].d1, tbl[i].busy);
      check($sformatf("row%0d send", i), 32'(serial_send), 32'(tbl[i].send));
      check($sformatf("row%0d golden", i), golden_nonce, tbl[i].golden);
      check($sformatf("row%0d pending", i), 32'(pending), 32'(tbl[i].pend));
      check($sformatf("row%0d overflow", i), 32'(overflow), 32'(tbl[i].ovf));
    end
    do_reset();
    model = 1'b1;
    tick(2'b11, 32'hA, 32'hB, 1'b0);
    tick(2'b11, 32'hC, 32'hD, 1'b0);
    repeat (100) tick(2'b00, 32'h0, 32'h0, 1'b0);
    check("rr count", sent_q.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("rr word%0d", i), sent_q.size() > i ? sent_q[i] : 32'hdead, rr_exp[i]);
    check("rr overflow", 32'(overflow), 32'h0);
    do_reset();
    tick(2'b01, 32'h1, 32'h0, 1'b1);
    tick(2'b01, 32'h2, 32'h0, 1'b1);
    model = 1'b1;
    tick(2'b01, 32'h3, 32'h0, 1'b0);
    check("fullpop send", 32'(serial_send), 32'h1);
    check("fullpop overflow", 32'(overflow), 32'h0);
    repeat (80) tick(2'b00, 32'h0, 32'h0, 1'b0);
    check("fullpop count", sent_q.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("fullpop word%0d", i), sent_q.size() > i ? sent_q[i] : 32'hdead, fp_exp[i]);
    check("fullpop overflow end", 32'(overflow), 32'h0);
    do_reset();
    tick(2'b01, 32'h77, 32'h0, 1'b0);
    tick(2'b01, 32'h88, 32'h0, 1'b0);
    check("midrst send", 32'(serial_send), 32'h1);
    tick(2'b00, 32'h0, 32'h0, 1'b0);
    check("midrst pending before", 32'(pending), 32'h1);
    @(negedge hash_clk);
    reset = 1'b1;
    #1;
    check("midrst send async", 32'(serial_send), 32'h0);
    check("midrst pending async", 32'(pending), 32'h0);
    #2;
    reset = 1'b0;
    sent_q.delete();
    model = 1'b1;
    repeat (30) tick(2'b00, 32'h0, 32'h0, 1'b0);
    check("midrst no sends", sent_q.size(), 32'd0);
    check("midrst pending end", 32'(pending), 32'h0);
    do_reset();
    model = 1'b1;
    tick(2'b01, 32'h55, 32'h0, 1'b0);
    tick(2'b01, 32'h55, 32'h0, 1'b0);
    repeat (50) tick(2'b00, 32'h0, 32'h0, 1'b0);
    check("dedup sends", sent_q.size(), 32'(dedup_exp));
    check("dedup word", sent_q.size() > 0 ? sent_q[0] : 32'hdead, 32'h55);
    check("dedup pending", 32'(pending), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
